btn_debounce_sync: RTL and testbench
====================================

// Module: btn_debounce_sync
// PURPOSE
//   Multi-channel push-button conditioner for the digital clock front panel.
//   - Synchronises raw asynchronous button pins into clk with a 2-FF chain.
//   - Filters contact bounce with a per-channel stability counter.
//   - Flags long presses.
//   btn_db feeds the one-shot edge detector directly (level in, 1-cycle pulse out).
//   btn_hold feeds the time-set logic for fast-advance.
// PARAMETERS
//   WIDTH            1         number of independent button channels
//   DEBOUNCE_CYCLES  500000    clocks input must be stable to change btn_db (10 ms @ 50 MHz); must be >= 2
//   HOLD_CYCLES      50000000  clocks btn_db must stay 1 before btn_hold asserts (1 s @ 50 MHz); must be >= 1
//   ACTIVE_LOW       0         1 = pressed pin reads 0; input inverted before the synchroniser
// PORTS
//   clk       input   1      system clock
//   rst_n     input   1      asynchronous active-low reset
//   btn       input   WIDTH  raw button pins, asynchronous to clk
//   btn_db    output  WIDTH  debounced level, 1 = pressed (registered)
//   btn_hold  output  WIDTH  long-press flag, 1 = held >= HOLD_CYCLES (registered)
// BEHAVIOUR
//   Reset and ports
//   - Reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
//   - On !rst_n, every flop clears to 0 asynchronously: sync chain, debounce counters, hold counters, btn_db, btn_hold.
//   - The sync chain holds the post-inversion value, so reset state = released on every channel.
//   Input path
//   - Stage: p = ACTIVE_LOW ? ~btn : btn.
//   - s1 <= p; s2 <= s1.
//   - Only s2 is used downstream. Raw btn never reaches any other logic.
//   Debounce (per channel i, independent)
//   - Counter dcnt[i] is $clog2(DEBOUNCE_CYCLES) bits wide.
//   - If s2[i] == btn_db[i]: dcnt[i] <= 0. Any agreeing cycle restarts the window, so glitches are fully rejected.
//   - Else if dcnt[i] == DEBOUNCE_CYCLES-1: btn_db[i] <= s2[i] and dcnt[i] <= 0.
//   - Else: dcnt[i] <= dcnt[i] + 1.
//   - Latency: the new level is first sampled into s1 at edge 0. btn_db changes at edge DEBOUNCE_CYCLES+1.
//   - Press and release use identical timing (symmetric filter).
//   Hold detect (per channel i)
//   - Counter hcnt[i] is $clog2(HOLD_CYCLES+1) bits wide.
//   - If btn_db[i] == 0: hcnt[i] <= 0 and btn_hold[i] <= 0.
//   - Else if hcnt[i] == HOLD_CYCLES-1: btn_hold[i] <= 1 and hcnt[i] holds (saturates, no wrap).
//   - Else: hcnt[i] <= hcnt[i] + 1.
//   - btn_hold rises HOLD_CYCLES edges after btn_db rises.
//   - btn_hold falls on the edge after btn_db falls.
//   - Invariant: btn_hold[i] == 1 implies btn_db[i] == 1, except for that single cycle.
//   Boundary cases
//   - Reset mid-count clears all counters. No partial window survives reset.
//   - After rst_n deasserts, a button already pressed needs a full DEBOUNCE_CYCLES+1 to appear on btn_db.
//   - Channels never interact. Simultaneous presses are each filtered on their own counter.
//   - No counter ever wraps: dcnt resets on flip or on agreement, and hcnt saturates.
// TESTING (bench params: WIDTH=3, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, ACTIVE_LOW=0)
//   1. Reset: rst_n=0 with btn=3'b111 -> btn_db=0 and btn_hold=0 immediately (async, no clock edge needed).
//   2. Clean press: btn[0] 0->1 sampled at edge 0, then held -> btn_db[0]=1 after edge 5.
//      Mid-filter: btn_db[0] still 0 after edge 4.
//   3. Bounce: btn[1] toggles 1,0,1,0 on consecutive cycles, then stays 1 -> btn_db[1] rises 5 edges after the last toggle.
//      No intermediate pulse appears on btn_db[1].
//   4. Long press: btn[2] held 1 -> btn_hold[2] rises 10 edges after btn_db[2] rises.
//      Release btn[2] -> btn_db[2] falls after 5 edges; btn_hold[2] falls 1 edge later.
//   5. Reset mid-operation: assert rst_n=0 with dcnt[0]=2 during a press, then release reset with btn[0] still 1
//      -> btn_db[0] rises exactly 5 edges after reset release.
//   6. ACTIVE_LOW=1 instance: idle btn=3'b111 -> btn_db=0.
//      btn[0]=0 held -> btn_db[0]=1 after 5 edges.

Source files
------------

// File: rtl/btn_debounce_sync_if.sv
// -----------------------------------------------------------------------------
// btn_debounce_sync_if
//
// Purpose
//   Bundles the button-conditioner signals so the panel logic and the
//   conditioner agree on one set of widths.
//
// Signals (WIDTH = number of button channels)
//   btn       raw button pins, asynchronous to any clock
//   btn_db    debounced level, 1 = pressed (registered in the conditioner)
//   btn_hold  long-press flag, 1 = held long enough (registered)
//
// Modports
//   master  the side that owns the pins and consumes the conditioned levels
//   slave   the conditioner itself
//
// There is no valid/ready handshake here: btn is a free-running level and
// btn_db / btn_hold are levels that are valid on every clock once out of reset.
// -----------------------------------------------------------------------------
interface btn_debounce_sync_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] btn;
    logic [WIDTH-1:0] btn_db;
    logic [WIDTH-1:0] btn_hold;

    modport master (
        output btn,
        input  btn_db,
        input  btn_hold
    );

    modport slave (
        input  btn,
        output btn_db,
        output btn_hold
    );
endinterface

// File: rtl/btn_debounce_sync.sv
// -----------------------------------------------------------------------------
// btn_debounce_sync
//
// Purpose
//   Multi-channel push-button conditioner for the clock front panel.
//   Each channel is synchronised into clk with a two-flop chain, filtered for
//   contact bounce with its own stability counter, and flagged as a long press
//   once the debounced level has stayed high long enough.
//   btn_db is a level meant for a downstream one-shot edge detector; btn_hold
//   drives fast-advance in the time-set logic.
//
// Parameters
//   WIDTH            number of independent button channels
//   DEBOUNCE_CYCLES  clocks the synchronised input must differ from btn_db,
//                    without interruption, before btn_db follows it (>= 2)
//   HOLD_CYCLES      clocks btn_db must stay 1 before btn_hold asserts (>= 1)
//   ACTIVE_LOW       1 = a pressed pin reads 0; pins are inverted before the
//                    synchroniser so everything downstream is active-high
//
// Ports
//   clk    system clock
//   rst_n  asynchronous active-low reset; clears every flop to 0
//   bus    slave modport of btn_debounce_sync_if:
//            bus.btn       raw pins in
//            bus.btn_db    debounced level out (registered)
//            bus.btn_hold  long-press flag out (registered)
//
// Timing (press and release are symmetric)
//   A new pin level captured into the first sync flop at edge 0 reaches the
//   second flop at edge 1, then needs DEBOUNCE_CYCLES-1 further disagreeing
//   edges to reach the terminal count, so btn_db changes at edge
//   DEBOUNCE_CYCLES+1. btn_hold rises HOLD_CYCLES edges after btn_db rises and
//   falls on the edge after btn_db falls.
// -----------------------------------------------------------------------------
module btn_debounce_sync #(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    btn_debounce_sync_if.slave bus
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    // Hold counter reaches HOLD_CYCLES-1; the +1 keeps at least one bit when
    // HOLD_CYCLES == 1.
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HCNT_LAST = HW'(HOLD_CYCLES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] s1_q,   s1_d;     // first synchroniser stage
    logic [WIDTH-1:0] s2_q,   s2_d;     // second stage, only consumer of pins
    logic [DW-1:0]    dcnt_q [WIDTH];   // per-channel stability counter
    logic [DW-1:0]    dcnt_d [WIDTH];
    logic [WIDTH-1:0] db_q,   db_d;     // debounced level
    logic [HW-1:0]    hcnt_q [WIDTH];   // per-channel hold counter
    logic [HW-1:0]    hcnt_d [WIDTH];
    logic [WIDTH-1:0] hold_q, hold_d;   // long-press flag

    // Pin polarity is normalised before the synchroniser, so the reset value
    // of the chain (all zeros) means "released" for either polarity.
    logic [WIDTH-1:0] pin_norm;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        pin_norm = ACTIVE_LOW ? ~bus.btn : bus.btn;

        s1_d   = pin_norm;
        s2_d   = s1_q;
        db_d   = db_q;
        hold_d = hold_q;

        for (int i = 0; i < WIDTH; i++) begin
            dcnt_d[i] = dcnt_q[i];
            hcnt_d[i] = hcnt_q[i];

            // Debounce: any cycle where the input agrees with the current
            // output restarts the window, so a glitch shorter than the window
            // never gets through and never leaves a partial count behind.
            if (s2_q[i] == db_q[i]) begin
                dcnt_d[i] = '0;
            end else if (dcnt_q[i] == DCNT_LAST) begin
                db_d[i]   = s2_q[i];
                dcnt_d[i] = '0;
            end else begin
                dcnt_d[i] = dcnt_q[i] + DW'(1);
            end

            // Hold detect works on the registered debounced level, which is
            // why btn_hold drops one edge after btn_db does.
            if (!db_q[i]) begin
                hcnt_d[i] = '0;
                hold_d[i] = 1'b0;
            end else if (hcnt_q[i] == HCNT_LAST) begin
                // Saturate here: the counter parks at the terminal value for
                // as long as the button stays down.
                hold_d[i] = 1'b1;
            end else begin
                hcnt_d[i] = hcnt_q[i] + HW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s2_q   <= '0;
            db_q   <= '0;
            hold_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                dcnt_q[i] <= '0;
                hcnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            db_q   <= db_d;
            hold_q <= hold_d;
            for (int i = 0; i < WIDTH; i++) begin
                dcnt_q[i] <= dcnt_d[i];
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs come straight from flops.
    // -------------------------------------------------------------------------
    assign bus.btn_db   = db_q;
    assign bus.btn_hold = hold_q;

endmodule

// File: tb/tb_btn_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_sync
//
// Directed bench for btn_debounce_sync with WIDTH=3, DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=10. Two instances share clock and reset: dut_h (ACTIVE_LOW=0)
// and dut_l (ACTIVE_LOW=1). Inputs change 1 time unit after a rising edge, so
// the next rising edge is "edge 0" for that change; outputs are sampled
// 1 time unit after an edge.
// -----------------------------------------------------------------------------
module tb_btn_debounce_sync;

    localparam int W  = 3;
    localparam int DB = 4;
    localparam int HC = 10;

    // ---------------------------------------------------------------- clock/reset
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    btn_debounce_sync_if #(.WIDTH(W)) bus_h ();
    btn_debounce_sync_if #(.WIDTH(W)) bus_l ();

    btn_debounce_sync #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .ACTIVE_LOW(1'b0)
    ) dut_h (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_h)
    );

    btn_debounce_sync #(
        .WIDTH(W), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HC), .ACTIVE_LOW(1'b1)
    ) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_l)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    // Advance n rising edges, then settle 1 unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Safety net: the sequence below is fixed-length, this only fires if the
    // simulation stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    logic [3:0] bounce_pat;

    initial begin
        bounce_pat = 4'b0101;   // bit k is the level driven on cycle k: 1,0,1,0
        rst_n      = 1'b1;
        bus_h.btn  = 3'b111;
        bus_l.btn  = 3'b111;

        // 1. Asynchronous reset: outputs clear before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_db",     32'(bus_h.btn_db),   32'h0);
        check("rst_async_hold",   32'(bus_h.btn_hold), 32'h0);
        check("rst_async_db_al",  32'(bus_l.btn_db),   32'h0);

        step(3);
        check("rst_held_db",      32'(bus_h.btn_db),   32'h0);
        bus_h.btn = 3'b000;
        step(1);
        rst_n = 1'b1;
        step(8);
        check("idle_db",          32'(bus_h.btn_db),   32'h0);
        check("idle_db_al",       32'(bus_l.btn_db),   32'h0);
        check("idle_hold_al",     32'(bus_l.btn_hold), 32'h0);

        // 2. Clean press on channel 0.
        bus_h.btn = 3'b001;
        step(5);
        check("press_edge4_db0",  32'(bus_h.btn_db[0]), 32'h0);
        step(1);
        check("press_edge5_db0",  32'(bus_h.btn_db[0]), 32'h1);
        check("press_edge5_db",   32'(bus_h.btn_db),    32'h1);

        // 3. Bounce on channel 1: one-cycle toggles never make it through.
        for (int k = 0; k < 4; k++) begin
            bus_h.btn[1] = bounce_pat[k];
            step(1);
            check($sformatf("bounce_toggle%0d_db1", k), 32'(bus_h.btn_db[1]), 32'h0);
        end
        bus_h.btn[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check($sformatf("bounce_settle_edge%0d_db1", k), 32'(bus_h.btn_db[1]), 32'h0);
        end
        step(1);
        check("bounce_edge5_db1", 32'(bus_h.btn_db[1]), 32'h1);

        // 4. Long press on channel 2.
        bus_h.btn[2] = 1'b1;
        step(5);
        check("long_edge4_db2",   32'(bus_h.btn_db[2]),   32'h0);
        step(1);
        check("long_edge5_db2",   32'(bus_h.btn_db[2]),   32'h1);
        check("long_edge5_hold2", 32'(bus_h.btn_hold[2]), 32'h0);
        step(9);
        check("long_edge14_hold2", 32'(bus_h.btn_hold[2]), 32'h0);
        step(1);
        check("long_edge15_hold2", 32'(bus_h.btn_hold[2]), 32'h1);
        step(5);
        check("long_sat_hold2",   32'(bus_h.btn_hold[2]), 32'h1);
        // Channels 0 and 1 have been down well over HOLD_CYCLES by now.
        check("long_all_hold",    32'(bus_h.btn_hold),    32'h7);

        // Release channel 2.
        bus_h.btn[2] = 1'b0;
        step(5);
        check("rel_edge4_db2",    32'(bus_h.btn_db[2]),   32'h1);
        check("rel_edge4_hold2",  32'(bus_h.btn_hold[2]), 32'h1);
        step(1);
        check("rel_edge5_db2",    32'(bus_h.btn_db[2]),   32'h0);
        check("rel_edge5_hold2",  32'(bus_h.btn_hold[2]), 32'h1);
        step(1);
        check("rel_edge6_hold2",  32'(bus_h.btn_hold[2]), 32'h0);
        check("rel_other_db",     32'(bus_h.btn_db[1:0]), 32'h3);

        // 5. Reset in the middle of a debounce window.
        bus_h.btn = 3'b000;
        step(10);
        check("clear_db",         32'(bus_h.btn_db),   32'h0);
        check("clear_hold",       32'(bus_h.btn_hold), 32'h0);
        bus_h.btn = 3'b001;
        step(4);                        // channel 0 counter is at 2 here
        rst_n = 1'b0;
        #1;
        check("midrst_db",        32'(bus_h.btn_db),   32'h0);
        step(2);
        rst_n = 1'b1;
        step(5);
        check("midrst_edge4_db0", 32'(bus_h.btn_db[0]), 32'h0);
        step(1);
        check("midrst_edge5_db0", 32'(bus_h.btn_db[0]), 32'h1);

        // 6. Active-low instance: pin 0 pulled low is a press.
        check("al_idle_db",       32'(bus_l.btn_db),   32'h0);
        bus_l.btn = 3'b110;
        step(5);
        check("al_edge4_db",      32'(bus_l.btn_db),   32'h0);
        step(1);
        check("al_edge5_db",      32'(bus_l.btn_db),   32'h1);
        check("al_edge5_hold",    32'(bus_l.btn_hold), 32'h0);

        // ---------------------------------------------------------------- report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
